// File: rtl/prog_rom_ctrl.sv
// Program-store controller: a 16 x 8 instruction store read by the CPU, reloadable
// through a byte-stream loader port, with a CPU reset pulse issued after each load.
module prog_rom_ctrl #(
    parameter int AUTO_LOAD  = 0,
    parameter int RST_CYCLES = 1
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] A,
    output logic [7:0] Q,
    input  logic       ld_start,
    input  logic       ld_abort,
    input  logic       ld_valid,
    input  logic [7:0] ld_data,
    output logic       ld_ready,
    output logic [3:0] ld_ptr,
    output logic       cpu_run,
    output logic       cpu_rst,
    output logic       err
);

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_LOAD    = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    localparam state_t     RST_STATE = (AUTO_LOAD != 0) ? S_LOAD : S_RUN;
    localparam logic [3:0] REL_LAST  = 4'(RST_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] ptr_q, ptr_d;
    logic [3:0] cnt_q, cnt_d;
    logic       err_q, err_d;
    logic       wr_en;
    logic [7:0] mem_q [16];

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= RST_STATE;
            ptr_q   <= 4'd0;
            cnt_q   <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        wr_en   = 1'b0;
        case (state_q)
            S_RUN: begin
                // A start request outranks both abort and a stray byte in the same cycle.
                if (ld_start) begin
                    state_d = S_LOAD;
                    ptr_d   = 4'd0;
                    err_d   = 1'b0;
                end else if (ld_valid) begin
                    err_d = 1'b1;
                end
            end
            S_LOAD: begin
                if (ld_valid) begin
                    wr_en = 1'b1;
                    ptr_d = ptr_q + 4'd1;
                end
                if (ld_abort || (ld_valid && (ptr_q == 4'hF))) begin
                    state_d = S_RELEASE;
                    cnt_d   = 4'd0;
                end
            end
            S_RELEASE: begin
                if (ld_valid) begin
                    err_d = 1'b1;
                end
                if (cnt_q == REL_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = RST_STATE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // The store is cleared on reset so an abandoned load leaves no partial program.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < 16; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (wr_en) begin
            mem_q[ptr_q] <= ld_data;
        end
    end

    assign Q        = mem_q[A];
    assign ld_ready = (state_q == S_LOAD);
    assign cpu_run  = (state_q == S_RUN);
    assign cpu_rst  = (state_q == S_RELEASE);
    assign ld_ptr   = ptr_q;
    assign err      = err_q;

endmodule

// File: tb/tb_prog_rom_ctrl.sv
// Bench for prog_rom_ctrl: two instances (plain, and auto-load with a 3-cycle CPU
// reset) driven in parallel and compared against a behavioural model every cycle.
module tb_prog_rom_ctrl;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [3:0] A;
    logic       ld_start, ld_abort, ld_valid;
    logic [7:0] ld_data;

    logic [7:0] q_a, q_b;
    logic       rdy_a, rdy_b, run_a, run_b, rst_a, rst_b, err_a, err_b;
    logic [3:0] ptr_a, ptr_b;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: mode 0 = CPU running, 1 = accepting bytes, 2 = CPU held in reset.
    int         m_mode [2];
    int         m_left [2];
    int         m_ptr  [2];
    logic       m_err  [2];
    logic [7:0] m_mem  [2][16];
    int         m_rc   [2] = '{1, 3};
    int         m_al   [2] = '{0, 1};

    prog_rom_ctrl #(.AUTO_LOAD(0), .RST_CYCLES(1)) dut_a (
        .CLK(CLK), .RESET(RESET), .A(A), .Q(q_a),
        .ld_start(ld_start), .ld_abort(ld_abort), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_ready(rdy_a), .ld_ptr(ptr_a), .cpu_run(run_a), .cpu_rst(rst_a), .err(err_a)
    );

    prog_rom_ctrl #(.AUTO_LOAD(1), .RST_CYCLES(3)) dut_b (
        .CLK(CLK), .RESET(RESET), .A(A), .Q(q_b),
        .ld_start(ld_start), .ld_abort(ld_abort), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_ready(rdy_b), .ld_ptr(ptr_b), .cpu_run(run_b), .cpu_rst(rst_b), .err(err_b)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = m_al[i];
            m_left[i] = 0;
            m_ptr[i]  = 0;
            m_err[i]  = 1'b0;
            for (int j = 0; j < 16; j++) m_mem[i][j] = 8'h00;
        end
    endtask

    task automatic model_step(input int i);
        bit done;
        case (m_mode[i])
            0: begin
                if (ld_start) begin
                    m_mode[i] = 1;
                    m_ptr[i]  = 0;
                    m_err[i]  = 1'b0;
                end else if (ld_valid) begin
                    m_err[i] = 1'b1;
                end
            end
            1: begin
                done = ld_abort;
                if (ld_valid) begin
                    m_mem[i][m_ptr[i]] = ld_data;
                    if (m_ptr[i] == 15) done = 1'b1;
                    m_ptr[i] = (m_ptr[i] + 1) % 16;
                end
                if (done) begin
                    m_mode[i] = 2;
                    m_left[i] = m_rc[i];
                end
            end
            default: begin
                if (ld_valid) m_err[i] = 1'b1;
                m_left[i]--;
                if (m_left[i] == 0) m_mode[i] = 0;
            end
        endcase
    endtask

    task automatic check_all();
        chk("a_cpu_run",  8'(run_a), 8'(m_mode[0] == 0));
        chk("a_ld_ready", 8'(rdy_a), 8'(m_mode[0] == 1));
        chk("a_cpu_rst",  8'(rst_a), 8'(m_mode[0] == 2));
        chk("a_ld_ptr",   8'(ptr_a), 8'(m_ptr[0]));
        chk("a_err",      8'(err_a), 8'(m_err[0]));
        chk("a_q",        q_a,       m_mem[0][A]);
        chk("b_cpu_run",  8'(run_b), 8'(m_mode[1] == 0));
        chk("b_ld_ready", 8'(rdy_b), 8'(m_mode[1] == 1));
        chk("b_cpu_rst",  8'(rst_b), 8'(m_mode[1] == 2));
        chk("b_ld_ptr",   8'(ptr_b), 8'(m_ptr[1]));
        chk("b_err",      8'(err_b), 8'(m_err[1]));
        chk("b_q",        q_b,       m_mem[1][A]);
    endtask

    task automatic step();
        @(posedge CLK);
        model_step(0);
        model_step(1);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        ld_start = 0; ld_abort = 0; ld_valid = 0;
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic send(input logic [7:0] d);
        ld_start = 0; ld_abort = 0; ld_valid = 1; ld_data = d;
        step();
        ld_valid = 0;
    endtask

    initial begin
        int cnt_rst_a, cnt_rst_b, cnt_run_b;
        logic [7:0] pat;

        RESET = 1; A = 4'd0;
        ld_start = 0; ld_abort = 0; ld_valid = 0; ld_data = 8'h00;
        model_reset();
        #1;
        check_all();
        @(negedge CLK);
        @(negedge CLK);
        RESET = 0;
        idle(1);

        // Abort after three bytes from a cleared store.
        ld_start = 1; step(); ld_start = 0;
        send(8'hAA); send(8'hBB); send(8'hCC);
        ld_abort = 1; step(); ld_abort = 0;
        idle(5);
        A = 4'd0; #1; chk("abort_q0", q_a, 8'hAA);
        A = 4'd1; #1; chk("abort_q1", q_a, 8'hBB);
        A = 4'd2; #1; chk("abort_q2", q_a, 8'hCC);
        A = 4'd3; #1; chk("abort_q3", q_a, 8'h00);

        // Stray byte while running, cleared by the next start.
        ld_valid = 1; ld_data = 8'h5A; step(); ld_valid = 0;
        chk("stray_err", 8'(err_a), 8'h01);
        chk("stray_q3", q_a, 8'h00);
        ld_start = 1; step(); ld_start = 0;
        chk("start_clr_err", 8'(err_a), 8'h00);
        ld_abort = 1; step(); ld_abort = 0;
        idle(5);

        // Gapped valid: only valid cycles move the pointer.
        ld_start = 1; step(); ld_start = 0;
        pat = 8'b0010_1001;
        for (int k = 0; k < 8; k++) begin
            ld_valid = pat[k]; ld_data = 8'(8'h40 + k);
            step();
        end
        ld_valid = 0;
        chk("gap_ptr", 8'(ptr_a), 8'h03);
        ld_abort = 1; step(); ld_abort = 0;
        idle(5);

        // Full 16-byte load on both instances.
        ld_start = 1; step(); ld_start = 0;
        for (int k = 0; k < 16; k++) send(8'(8'h10 + k));
        chk("full_rst_a", 8'(rst_a), 8'h01);
        chk("full_ptr_wrap", 8'(ptr_a), 8'h00);
        cnt_rst_a = 1; cnt_rst_b = 1; cnt_run_b = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            cnt_rst_a += int'(rst_a);
            cnt_rst_b += int'(rst_b);
            if (rst_b && run_b) cnt_run_b++;
        end
        chk("rst_width_1", 8'(cnt_rst_a), 8'd1);
        chk("rst_width_3", 8'(cnt_rst_b), 8'd3);
        chk("run_during_rst", 8'(cnt_run_b), 8'd0);
        chk("run_after_b", 8'(run_b), 8'h01);
        A = 4'h5; #1;
        chk("full_q5", q_a, 8'h15);
        chk("full_q5_b", q_b, 8'h15);

        // Randomised traffic.
        for (int k = 0; k < 800; k++) begin
            ld_start = ($urandom % 20) == 0;
            ld_abort = ($urandom % 12) == 0;
            ld_valid = $urandom % 2;
            ld_data  = 8'($urandom);
            A        = 4'($urandom);
            step();
        end

        // Reset part-way through a load.
        idle(6);
        ld_start = 1; step(); ld_start = 0;
        for (int k = 0; k < 7; k++) send(8'($urandom));
        chk("pre_rst_ptr", 8'(ptr_a), 8'h07);
        #2;
        RESET = 1;
        #1;
        model_reset();
        check_all();
        chk("rst_ptr", 8'(ptr_a), 8'h00);
        chk("rst_run", 8'(run_a), 8'h01);
        chk("rst_cpu_rst", 8'(rst_a), 8'h00);
        for (int k = 0; k < 16; k++) begin
            A = 4'(k); #1;
            chk("rst_store", q_a, 8'h00);
        end
        @(negedge CLK);
        RESET = 0;
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
